flash_read_responder: RTL and testbench

FLASH_READ_RESPONDER -- requirements
Module: flash_read_responder

---
 rtl/flash_read_responder.sv | 157 +++++++++++++++
 tb/tb_flash_read_responder.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/flash_read_responder.sv
// flash_read_responder: SPI mode-0 read engine for the weight/bias table.
// One 03h read of two bytes per request, packed into a 16-bit word.
module flash_read_responder #(
  parameter int unsigned CLK_DIV   = 2,
  parameter logic [23:0] BASE_ADDR = 24'h000000
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        flash_ready,
  input  logic [15:0] flash_address,
  output logic [15:0] flashData_out,
  output logic        data_valid,
  output logic        busy,
  output logic        spi_cs_n,
  output logic        spi_sck,
  output logic        spi_mosi,
  input  logic        spi_miso
);

  typedef enum logic [2:0] {
    IDLE, CMD, ADDR, DATA, DONE, GAP
  } state_t;

  localparam logic [7:0] READ_CMD = 8'h03;
  localparam logic [3:0] DIV_LAST = 4'(CLK_DIV - 1);

  state_t      state;
  state_t      state_nx;
  logic [3:0]  div_cnt;
  logic        phase_hi;
  logic [4:0]  bit_cnt;
  logic [4:0]  last_bit;
  logic [23:0] addr_q;
  logic [15:0] rx_q;
  logic        xfer;
  logic        half_end;
  logic        phase_end;
  logic        accept;
  logic        sample;
  logic        cs_n_d;
  logic        sck_d;
  logic        mosi_d;
  logic        busy_d;

  assign xfer      = (state == CMD) ||
                     (state == ADDR) ||
                     (state == DATA);
  assign half_end  = div_cnt == DIV_LAST;
  assign phase_end = half_end && phase_hi &&
                     (bit_cnt == last_bit);
  assign accept    = (state == IDLE) && flash_ready;
  // sck_q rises on the edge that ends the low half
  assign sample    = (state == DATA) && phase_hi &&
                     (div_cnt == 4'd0);

  // last bit index of the current serial phase
  always_comb begin
    last_bit = 5'd0;
    unique case (1'b1)
      state == CMD:  last_bit = 5'd7;
      state == ADDR: last_bit = 5'd23;
      state == DATA: last_bit = 5'd15;
      default:       last_bit = 5'd0;
    endcase
  end

  // state register
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state <= IDLE;
    else        state <= state_nx;
  end

  // next-state logic
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (flash_ready) state_nx = CMD;
      CMD:  if (phase_end)   state_nx = ADDR;
      ADDR: if (phase_end)   state_nx = DATA;
      DATA: if (phase_end)   state_nx = DONE;
      DONE:                  state_nx = GAP;
      GAP:  if (half_end)    state_nx = IDLE;
      default:               state_nx = IDLE;
    endcase
  end

  // divider, half-phase and bit counters, cleared on phase change
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      div_cnt  <= '0;
      phase_hi <= 1'b0;
      bit_cnt  <= '0;
    end else if (state_nx != state) begin
      div_cnt  <= '0;
      phase_hi <= 1'b0;
      bit_cnt  <= '0;
    end else if (xfer) begin
      if (half_end) begin
        div_cnt  <= '0;
        phase_hi <= ~phase_hi;
        if (phase_hi) bit_cnt <= bit_cnt + 5'd1;
      end else begin
        div_cnt <= div_cnt + 4'd1;
      end
    end else if (state == GAP) begin
      div_cnt <= div_cnt + 4'd1;
    end
  end

  // address latch at acceptance and read-data shifter
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      addr_q <= '0;
      rx_q   <= '0;
    end else begin
      if (accept)
        addr_q <= BASE_ADDR +
                  {7'b0, flash_address, 1'b0};
      if (sample)
        rx_q <= {rx_q[14:0], spi_miso};
    end
  end

  // next values of the serial pins and status
  always_comb begin
    cs_n_d = ~(xfer || accept);
    sck_d  = xfer && phase_hi;
    busy_d = state_nx != IDLE;
    mosi_d = 1'b0;
    unique case (state)
      CMD:     mosi_d = READ_CMD[3'(5'd7 - bit_cnt)];
      ADDR:    mosi_d = addr_q[5'(5'd23 - bit_cnt)];
      default: mosi_d = 1'b0;
    endcase
  end

  // glitch-free registered pins; cs_n drops with acceptance
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      spi_cs_n      <= 1'b1;
      spi_sck       <= 1'b0;
      spi_mosi      <= 1'b0;
      busy          <= 1'b0;
      data_valid    <= 1'b0;
      flashData_out <= '0;
    end else begin
      spi_cs_n   <= cs_n_d;
      spi_sck    <= sck_d;
      spi_mosi   <= mosi_d;
      busy       <= busy_d;
      data_valid <= state == DONE;
      if (state == DONE)
        flashData_out <= {rx_q[7:0], rx_q[15:8]};
    end
  end

endmodule

// File: tb/tb_flash_read_responder.sv
// tb_flash_read_responder: two DUTs (CLK_DIV 2 and 1) against a
// timeline model of the SPI read, plus directed literal checks.
module tb_flash_read_responder;

  logic        clk = 1'b0;
  logic        n_rst;
  logic        rdy       [2];
  logic [15:0] faddr     [2];
  logic [15:0] fdo       [2];
  logic        dv        [2];
  logic        busy      [2];
  logic        cs_n      [2];
  logic        sck       [2];
  logic        mosi      [2];
  logic        miso      [2];
  logic [15:0] fl_stream [2];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  flash_read_responder #(
    .CLK_DIV(2), .BASE_ADDR(24'h000000)
  ) u_d2 (
    .clk(clk), .n_rst(n_rst),
    .flash_ready(rdy[0]), .flash_address(faddr[0]),
    .flashData_out(fdo[0]), .data_valid(dv[0]),
    .busy(busy[0]), .spi_cs_n(cs_n[0]),
    .spi_sck(sck[0]), .spi_mosi(mosi[0]),
    .spi_miso(miso[0])
  );

  flash_read_responder #(
    .CLK_DIV(1), .BASE_ADDR(24'h010000)
  ) u_d1 (
    .clk(clk), .n_rst(n_rst),
    .flash_ready(rdy[1]), .flash_address(faddr[1]),
    .flashData_out(fdo[1]), .data_valid(dv[1]),
    .busy(busy[1]), .spi_cs_n(cs_n[1]),
    .spi_sck(sck[1]), .spi_mosi(mosi[1]),
    .spi_miso(miso[1])
  );

  for (genvar g = 0; g < 2; g++) begin : ch
    localparam int D = (g == 0) ? 2 : 1;
    localparam logic [23:0] B =
      (g == 0) ? 24'h000000 : 24'h010000;

    // flash device: captures cmd+addr, plays back 16 bits
    int          cnt = 0;
    logic [31:0] cap = '0;
    logic        dmosi = 1'b0;
    int          dvn = 0;
    int          nprint = 0;

    always @(negedge cs_n[g] or posedge sck[g]) begin
      if (!sck[g]) begin
        cnt = 0; cap = '0; dmosi = 1'b0;
      end else if (!cs_n[g]) begin
        if (cnt < 32) cap = {cap[30:0], mosi[g]};
        else dmosi = dmosi | mosi[g];
        cnt++;
      end
    end

    always @(negedge sck[g])
      if (cnt >= 32 && cnt < 48)
        miso[g] = fl_stream[g][47 - cnt];

    // model: time since acceptance drives every output
    bit          act = 1'b0;
    int          t = 0;
    logic [23:0] ea = '0;
    logic [15:0] ew = '0;
    logic [15:0] ed = '0;

    always @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
        act = 1'b0; t = 0; ed = '0;
      end else begin
        if (act) begin
          t++;
          if (t == 97 * D + 1) act = 1'b0;
        end else if (rdy[g]) begin
          act = 1'b1; t = 0;
          ea = B + {7'b0, faddr[g], 1'b0};
          ew = {fl_stream[g][7:0], fl_stream[g][15:8]};
        end
        if (act && t == 96 * D + 1) ed = ew;
      end
    end

    logic        e_cs, e_sck, e_mosi, e_dv, e_busy;
    logic [31:0] st;
    int          k, b;

    always @(negedge clk) begin
      st = {8'h03, ea};
      e_cs = 1'b1; e_sck = 1'b0; e_mosi = 1'b0;
      e_dv = 1'b0; e_busy = act;
      if (act && t <= 96 * D) e_cs = 1'b0;
      if (act && t >= 1 && t <= 96 * D) begin
        k = t - 1;
        e_sck = ((k / D) % 2) == 1;
        b = k / (2 * D);
        if (b < 32) e_mosi = st[31 - b];
      end
      if (act && t == 96 * D + 1) e_dv = 1'b1;
      if (dv[g] === 1'b1) dvn++;
      checks++;
      if ({cs_n[g], sck[g], mosi[g], dv[g], busy[g], fdo[g]} !==
          {e_cs, e_sck, e_mosi, e_dv, e_busy, ed}) begin
        errors++;
        if (nprint < 30) begin
          nprint++;
          $display("FAIL cycle ch%0d t=%0d got cs%b sck%b mosi%b dv%b busy%b d=%h want cs%b sck%b mosi%b dv%b busy%b d=%h",
            g, t, cs_n[g], sck[g], mosi[g], dv[g], busy[g], fdo[g],
            e_cs, e_sck, e_mosi, e_dv, e_busy, ed);
        end
      end
    end
  end

  task automatic chk(input string nm,
                     input logic [31:0] act_v,
                     input logic [31:0] exp_v);
    checks++;
    if (act_v !== exp_v) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, act_v, exp_v);
    end
  endtask

  task automatic wait_dv(input int g, input string nm,
                         output int lat);
    lat = -1;
    for (int n = 1; n <= 400; n++) begin
      @(posedge clk); #1;
      if (dv[g]) begin lat = n; break; end
    end
    if (lat < 0) begin
      checks++; errors++;
      $display("FAIL %s timeout got no data_valid want pulse", nm);
    end
  endtask

  task automatic wait_idle(input int g, input string nm);
    int q;
    q = 0;
    for (int n = 0; n < 400 && q < 3; n++) begin
      @(posedge clk); #1;
      if (!busy[g]) q++;
      else q = 0;
    end
    if (q < 3) begin
      checks++; errors++;
      $display("FAIL %s timeout got busy want idle", nm);
    end
  endtask

  task automatic request(input int g, input logic [15:0] a,
                         input string nm, output int lat);
    faddr[g] = a;
    rdy[g] = 1'b1;
    @(posedge clk); #1;
    rdy[g] = 1'b0;
    wait_dv(g, nm, lat);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got hang want finish");
    $fatal(1);
  end

  initial begin
    int lat, gap, dv0;
    n_rst = 1'b0;
    rdy = '{1'b0, 1'b0};
    faddr = '{16'h0, 16'h0};
    fl_stream = '{16'h0, 16'h0};
    repeat (3) @(posedge clk);
    #1;
    chk("rst_pins0", {cs_n[0], sck[0], mosi[0], busy[0], dv[0]},
        32'b10000);
    chk("rst_data0", fdo[0], 16'h0000);
    chk("rst_pins1", {cs_n[1], sck[1], mosi[1], busy[1], dv[1]},
        32'b10000);
    n_rst = 1'b1;
    @(posedge clk); #1;

    // basic read, CLK_DIV=2
    fl_stream[0] = 16'hA53C;
    request(0, 16'h0010, "t1", lat);
    chk("t1_latency", lat, 193);
    chk("t1_data", fdo[0], 16'h3CA5);
    chk("t1_model", ch[0].ed, 16'h3CA5);
    chk("t1_stream", ch[0].cap, 32'h03000020);
    chk("t1_mosi_data", ch[0].dmosi, 1'b0);
    wait_idle(0, "t1_idle");

    // CLK_DIV=1, offset base, top word address wraps past 64K
    fl_stream[1] = 16'h5AC3;
    request(1, 16'hFFFF, "t2", lat);
    chk("t2_latency", lat, 97);
    chk("t2_data", fdo[1], 16'hC35A);
    chk("t2_stream", ch[1].cap, 32'h0302FFFE);
    wait_idle(1, "t2_idle");

    // back-to-back with flash_ready held high
    dv0 = ch[0].dvn;
    fl_stream[0] = 16'h1122;
    faddr[0] = 16'h0001;
    rdy[0] = 1'b1;
    @(posedge clk); #1;
    wait_dv(0, "b2b_1", lat);
    chk("b2b_lat1", lat, 193);
    gap = 0;
    while (cs_n[0] && gap < 20) begin
      gap++;
      @(posedge clk); #1;
    end
    chk("b2b_gap", gap, 3);
    wait_dv(0, "b2b_2", lat);
    rdy[0] = 1'b0;
    chk("b2b_lat2", lat, 193);
    chk("b2b_data", fdo[0], 16'h2211);
    chk("b2b_stream", ch[0].cap, 32'h03000002);
    wait_idle(0, "b2b_idle");
    chk("b2b_dv_count", ch[0].dvn - dv0, 2);

    // request during ADDR with a new address is dropped
    dv0 = ch[0].dvn;
    fl_stream[0] = 16'h7788;
    faddr[0] = 16'h0123;
    rdy[0] = 1'b1;
    @(posedge clk); #1;
    rdy[0] = 1'b0;
    repeat (50) @(posedge clk);
    #1;
    faddr[0] = 16'h0456;
    rdy[0] = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rdy[0] = 1'b0;
    wait_dv(0, "tog", lat);
    chk("tog_stream", ch[0].cap, 32'h03000246);
    chk("tog_data", fdo[0], 16'h8877);
    wait_idle(0, "tog_idle");
    chk("tog_dv_count", ch[0].dvn - dv0, 1);

    // reset at DATA bit 10 aborts silently
    fl_stream[0] = 16'h1234;
    faddr[0] = 16'h0007;
    rdy[0] = 1'b1;
    @(posedge clk); #1;
    rdy[0] = 1'b0;
    repeat (170) @(posedge clk);
    #2;
    chk("rst_pre_cs", cs_n[0], 1'b0);
    dv0 = ch[0].dvn;
    n_rst = 1'b0;
    #1;
    chk("rst_mid_pins", {cs_n[0], sck[0], mosi[0], busy[0], dv[0]},
        32'b10000);
    chk("rst_mid_data", fdo[0], 16'h0000);
    repeat (2) @(posedge clk);
    #1;
    n_rst = 1'b1;
    repeat (200) @(posedge clk);
    #1;
    chk("rst_no_dv", ch[0].dvn - dv0, 0);
    fl_stream[0] = 16'hA53C;
    request(0, 16'h0010, "rst_after", lat);
    chk("rst_after_lat", lat, 193);
    chk("rst_after_data", fdo[0], 16'h3CA5);
    chk("rst_after_stream", ch[0].cap, 32'h03000020);
    wait_idle(0, "rst_after_idle");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
